// File: rtl/mem_wait_responder.sv
// Memory-side responder for the CPU memory interface (MOV / RW / MS / MOC).
// Takes one request at a time and holds it for WAIT_CYCLES wait states. It then
// performs a big-endian byte/halfword/word access on a byte array and raises MOC.
// The array is not reset, so a testbench can preload it hierarchically.
module mem_wait_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [2:0]  MS,
  input  logic [31:0] DataIn,
  input  logic [31:0] Address,
  output logic        MOC,
  output logic [31:0] DataOut,
  output logic        ERR
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_BITS-1:0] ONE_A     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] TWO_A     = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] THREE_A   = ADDR_BITS'(3);

  logic [7:0] memory [0:DEPTH-1];

  logic [1:0]           state;
  logic [3:0]           wait_cnt;

  logic [ADDR_BITS-1:0] addr_p0;
  logic                 rw_p0;
  logic [2:0]           ms_p0;
  logic [31:0]          data_p0;

  logic [ADDR_BITS-1:0] addr1_p0;
  logic [ADDR_BITS-1:0] addr2_p0;
  logic [ADDR_BITS-1:0] addr3_p0;
  logic [31:0]          raw_word;
  logic                 done;
  logic                 size_err;
  logic                 wr_en;
  logic                 unused_addr_hi;

  // Right-justify the raw big-endian bytes and zero/sign-extend by size.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] ms);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [31:0]        r;
    b8  = raw[31:24];
    h16 = raw[31:16];
    r   = raw;
    case (ms[1:0])
      2'b00: begin
        if (ms[2]) r = 32'(b8);
        else       r = {24'd0, b8};
      end
      2'b01: begin
        if (ms[2]) r = 32'(h16);
        else       r = {16'd0, h16};
      end
      default: r = raw;
    endcase
    return r;
  endfunction

  // Byte lanes wrap modulo the array depth through ADDR_BITS-wide arithmetic.
  assign addr1_p0 = addr_p0 + ONE_A;
  assign addr2_p0 = addr_p0 + TWO_A;
  assign addr3_p0 = addr_p0 + THREE_A;
  assign raw_word = {memory[addr_p0], memory[addr1_p0], memory[addr2_p0], memory[addr3_p0]};

  assign done     = (state == S_ACCESS) && (wait_cnt == 4'd0);
  assign size_err = (ms_p0[1:0] == 2'b11);
  assign wr_en    = done && !rw_p0 && !size_err;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_hi = ^Address[31:ADDR_BITS];

  // Request capture: the request is frozen when accepted from IDLE.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && MOV) begin
      addr_p0 <= Address[ADDR_BITS-1:0];
      rw_p0   <= RW;
      ms_p0   <= MS;
      data_p0 <= DataIn;
    end
  end

  // Store commit at the completion edge. Reset forces IDLE, which drops a pending write.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      case (ms_p0[1:0])
        2'b00: memory[addr_p0] <= data_p0[7:0];
        2'b01: begin
          memory[addr_p0]  <= data_p0[15:8];
          memory[addr1_p0] <= data_p0[7:0];
        end
        2'b10: begin
          memory[addr_p0]  <= data_p0[31:24];
          memory[addr1_p0] <= data_p0[23:16];
          memory[addr2_p0] <= data_p0[15:8];
          memory[addr3_p0] <= data_p0[7:0];
        end
        default: ;
      endcase
    end
  end

  // Handshake FSM: IDLE -> ACCESS (wait states) -> ACK (hold until MOV drops).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      MOC      <= 1'b0;
      ERR      <= 1'b0;
      DataOut  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MOV) begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            MOC   <= 1'b1;
            ERR   <= size_err;
            state <= S_ACK;
            if (rw_p0 && !size_err) DataOut <= extend_load(raw_word, ms_p0);
          end
        end
        S_ACK: begin
          if (!MOV) begin
            MOC   <= 1'b0;
            ERR   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Self-checking bench for mem_wait_responder: directed scenarios plus random
// transactions checked against a byte-array reference model.
module tb_mem_wait_responder;

  localparam int WC = 2;
  localparam int AB = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MOV;
  logic        RW;
  logic [2:0]  MS;
  logic [31:0] DataIn;
  logic [31:0] Address;
  logic        MOC;
  logic [31:0] DataOut;
  logic        ERR;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model_mem [256];
  logic [31:0] model_dout = 32'd0;

  mem_wait_responder #(.WAIT_CYCLES(WC), .ADDR_BITS(AB)) dut (
    .CLK(CLK), .RESET(RESET), .MOV(MOV), .RW(RW), .MS(MS),
    .DataIn(DataIn), .Address(Address), .MOC(MOC), .DataOut(DataOut), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Reference: memory as plain bytes, accesses as loops over 1/2/4 bytes.
  task automatic model_access(input logic rw, input logic [2:0] ms, input logic [31:0] din,
                              input logic [31:0] addr, output logic [31:0] exp_dout,
                              output logic exp_err);
    int    a;
    int    n;
    longint v;
    a = int'(addr % 256);
    n = 1 << ms[1:0];
    exp_err = 1'b0;
    if (ms[1:0] == 2'b11) begin
      exp_err = 1'b1;
    end else if (!rw) begin
      for (int k = 0; k < n; k++)
        model_mem[(a + k) % 256] = 8'(din >> (8 * (n - 1 - k)));
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v * 256 + longint'(model_mem[(a + k) % 256]);
      if (ms[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      model_dout = 32'(v);
    end
    exp_dout = model_dout;
  endtask

  // One full transaction; MOV held for 'hold' extra cycles after MOC.
  task automatic do_req(input logic rw, input logic [2:0] ms, input logic [31:0] din,
                        input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] exp_dout;
    logic        exp_err;
    int          lat;
    model_access(rw, ms, din, addr, exp_dout, exp_err);
    MOV = 1'b1; RW = rw; MS = ms; DataIn = din; Address = addr;
    @(posedge CLK); #1;
    if (hold == 0) MOV = 1'b0;
    RW = 1'($urandom); MS = 3'($urandom); DataIn = $urandom; Address = $urandom;
    lat = 0;
    while (!MOC && lat < 64) begin
      @(posedge CLK); #1;
      lat++;
    end
    n_checks++;
    if (lat !== WC + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected %0d", tag, lat, WC + 1);
    end
    n_checks++;
    if (DataOut !== exp_dout) begin
      n_fail++;
      $display("FAIL %s dataout: got %h expected %h", tag, DataOut, exp_dout);
    end
    n_checks++;
    if (ERR !== exp_err) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", tag, ERR, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (MOC !== 1'b1 || DataOut !== exp_dout || ERR !== exp_err) begin
        n_fail++;
        $display("FAIL %s hold%0d: got moc=%b dout=%h err=%b expected moc=1 dout=%h err=%b",
                 tag, h, MOC, DataOut, ERR, exp_dout, exp_err);
      end
    end
    MOV = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (MOC !== 1'b0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got moc=%b err=%b expected moc=0 err=0", tag, MOC, ERR);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; MOV = 1'b0; RW = 1'b0; MS = 3'd0; DataIn = 32'd0; Address = 32'd0;
    #3;
    n_checks++;
    if (MOC !== 1'b0 || ERR !== 1'b0 || DataOut !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: got moc=%b err=%b dout=%h expected 0/0/0", MOC, ERR, DataOut);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) do_req(1'b0, 3'b010, $urandom, 32'(i * 4), 0, "fill");
  endtask

  task automatic test_word_read();
    do_req(1'b0, 3'b000, 32'h000000E1, 32'd0, 0, "pre0");
    do_req(1'b0, 3'b000, 32'h000000A0, 32'd1, 0, "pre1");
    do_req(1'b0, 3'b000, 32'h00000010, 32'd2, 0, "pre2");
    do_req(1'b0, 3'b000, 32'h00000005, 32'd3, 0, "pre3");
    do_req(1'b1, 3'b010, 32'd0, 32'd0, 0, "word_read");
    n_checks++;
    if (DataOut !== 32'hE1A01005) begin
      n_fail++;
      $display("FAIL word_read_const: got %h expected e1a01005", DataOut);
    end
  endtask

  task automatic test_byte_signed();
    do_req(1'b0, 3'b000, 32'h123456F0, 32'd7, 0, "byte_wr");
    do_req(1'b1, 3'b100, 32'd0, 32'd7, 0, "byte_rd_s");
    n_checks++;
    if (DataOut !== 32'hFFFFFFF0) begin
      n_fail++;
      $display("FAIL byte_signed: got %h expected fffffff0", DataOut);
    end
    do_req(1'b1, 3'b000, 32'd0, 32'd7, 0, "byte_rd_u");
    n_checks++;
    if (DataOut !== 32'h000000F0) begin
      n_fail++;
      $display("FAIL byte_unsigned: got %h expected 000000f0", DataOut);
    end
    n_checks++;
    if (dut.memory[6] !== model_mem[6] || dut.memory[8] !== model_mem[8]) begin
      n_fail++;
      $display("FAIL byte_neighbours: got %h %h expected %h %h",
               dut.memory[6], dut.memory[8], model_mem[6], model_mem[8]);
    end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 3'b010, 32'hCAFEBABE, 32'h000000FE, 0, "wrap_wr");
    n_checks++;
    if (dut.memory[8'hFE] !== 8'hCA || dut.memory[8'hFF] !== 8'hFE ||
        dut.memory[8'h00] !== 8'hBA || dut.memory[8'h01] !== 8'hBE) begin
      n_fail++;
      $display("FAIL wrap_bytes: got %h %h %h %h expected ca fe ba be",
               dut.memory[8'hFE], dut.memory[8'hFF], dut.memory[8'h00], dut.memory[8'h01]);
    end
    do_req(1'b1, 3'b010, 32'd0, 32'h000000FE, 0, "wrap_rd");
    n_checks++;
    if (DataOut !== 32'hCAFEBABE) begin
      n_fail++;
      $display("FAIL wrap_read: got %h expected cafebabe", DataOut);
    end
  endtask

  task automatic test_hold_mov();
    do_req(1'b1, 3'b001, 32'd0, 32'd2, 5, "hold_rd");
    do_req(1'b1, 3'b101, 32'd0, 32'h00000300, 0, "after_hold");
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 3'b010, 32'd0, 32'd8, 0, "pre_mid");
    MOV = 1'b1; RW = 1'b0; MS = 3'b010; DataIn = 32'h5A5AA5A5; Address = 32'd4;
    @(posedge CLK); #1;
    MOV = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (MOC !== 1'b0 || DataOut !== 32'd0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got moc=%b dout=%h err=%b expected 0/0/0", MOC, DataOut, ERR);
    end
    #2;
    RESET = 1'b1;
    model_dout = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (MOC !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_idle: got moc=%b expected 0", MOC);
      end
    end
    n_checks++;
    if ({dut.memory[4], dut.memory[5], dut.memory[6], dut.memory[7]} !==
        {model_mem[4], model_mem[5], model_mem[6], model_mem[7]}) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got %h%h%h%h expected %h%h%h%h",
               dut.memory[4], dut.memory[5], dut.memory[6], dut.memory[7],
               model_mem[4], model_mem[5], model_mem[6], model_mem[7]);
    end
    do_req(1'b1, 3'b010, 32'd0, 32'd4, 0, "post_mid_rd");
  endtask

  task automatic test_err();
    do_req(1'b0, 3'b011, 32'h000000AA, 32'd0, 0, "err_wr");
    n_checks++;
    if (dut.memory[0] !== model_mem[0]) begin
      n_fail++;
      $display("FAIL err_mem: got %h expected %h", dut.memory[0], model_mem[0]);
    end
    do_req(1'b1, 3'b111, 32'd0, 32'd9, 1, "err_rd");
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++)
      do_req(1'($urandom), 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), "rand");
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (dut.memory[i] !== model_mem[i]) begin
        n_fail++;
        $display("FAIL rand_mem[%0d]: got %h expected %h", i, dut.memory[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_read();
    test_byte_signed();
    test_wrap();
    test_hold_mov();
    test_reset_mid();
    test_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
